// File: rtl/local_store_responder_if.sv
// Request/response bus between the SPU and the local store.
//   req_*  : single request channel (valid/ready), store when req_write = 1
//   rsp_*  : load-data channel (valid/ready), one beat per accepted load
// Bit numbering is big-endian: byte 0 of a quadword is bits [0:7].
interface local_store_responder_if;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [0:14]   req_addr;
   logic [0:127]  req_wdata;
   logic [0:15]   req_wmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [0:127]  rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/local_store_responder.sv
// Local store with a load-response FIFO.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (FIFO state only, storage kept)
//   flush : synchronous flush, discards buffered responses, blocks requests
//   bus   : slave side of local_store_responder_if
// Stores commit at the accepting edge with byte enables and produce no
// response. Loads push the addressed quadword into a RSP_DEPTH-entry FIFO
// at the accepting edge, so data appears the following cycle.
module local_store_responder #(
   parameter int LS_BYTES  = 32768,
   parameter int RSP_DEPTH = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   local_store_responder_if.slave  bus
);
   localparam int QW    = LS_BYTES / 16;
   localparam int IDX_W = $clog2(QW);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

   logic [0:127]      store_mem [QW];
   logic [0:127]      rsp_buf [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [IDX_W-1:0]  idx;
   logic              store_fire;
   logic              load_fire;
   logic              pop;
   logic              unused_addr_bits;

   // Low address bits select a byte within the quadword and are not needed.
   assign idx              = bus.req_addr[0:IDX_W-1];
   assign unused_addr_bits = ^bus.req_addr[IDX_W:14];

   // Readiness looks only at the registered count, so a pop in the same
   // cycle never lets a load slip into a full buffer.
   assign bus.req_ready = !flush && (bus.req_write || (count < DEPTH_C));
   assign store_fire    = bus.req_valid && bus.req_ready && bus.req_write;
   assign load_fire     = bus.req_valid && bus.req_ready && !bus.req_write;
   assign bus.rsp_valid = (count != '0);
   assign pop           = bus.rsp_valid && bus.rsp_ready;
   assign bus.rsp_rdata = bus.rsp_valid ? rsp_buf[rd_ptr] : '0;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         // Flush wins over a simultaneous pop.
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (load_fire) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)       rd_ptr <= ptr_inc(rd_ptr);
         case ({load_fire, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Response payload needs no reset: it is gated to zero while empty.
   always_ff @(posedge clock) begin
      if (load_fire) rsp_buf[wr_ptr] <= store_mem[idx];
   end

   // Storage survives reset and flush.
   always_ff @(posedge clock) begin
      if (store_fire) begin
         for (int b = 0; b < 16; b++) begin
            if (bus.req_wmask[b]) store_mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_local_store_responder.sv
module tb_local_store_responder;
   localparam int DEPTH = 2;

   logic clock;
   logic reset;
   logic flush;
   int   n_cmp;
   int   n_err;

   local_store_responder_if bus ();

   local_store_responder #(.LS_BYTES(32768), .RSP_DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: quadword store keyed by index, expected responses in a queue.
   logic [0:127] model_mem [int];
   logic [0:127] exp_q [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:127] merge(input logic [0:127] old, input logic [0:127] d,
                                          input logic [0:15] m);
      logic [0:127] r;
      r = old;
      for (int b = 0; b < 16; b++) begin
         if (m[b]) begin
            for (int k = 0; k < 8; k++) r[b*8 + k] = d[b*8 + k];
         end
      end
      return r;
   endfunction

   // One cycle: drive at negedge, check before the edge, advance model at the edge.
   task automatic step(input bit v, input bit w, input logic [0:14] a, input logic [0:127] d,
                       input logic [0:15] m, input bit rr, input bit fl);
      bit           exp_rdy;
      logic [0:127] exp_data;
      logic [0:127] old;
      int           qi;
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wmask = m;
      bus.rsp_ready = rr;
      flush         = fl;
      #1;
      qi       = int'(a) / 16;
      exp_rdy  = !fl && (w || exp_q.size() < DEPTH);
      exp_data = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
      chk("rsp_valid", 128'(bus.rsp_valid), 128'(exp_q.size() != 0));
      chk("rsp_rdata", bus.rsp_rdata, exp_data);
      @(posedge clock);
      if (fl) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
         if (v && exp_rdy && w) begin
            old = model_mem.exists(qi) ? model_mem[qi] : '0;
            model_mem[qi] = merge(old, d, m);
         end
         if (v && exp_rdy && !w) exp_q.push_back(model_mem[qi]);
      end
      @(negedge clock);
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 1'b0, '0, '0, '0, rr, 1'b0);
   endtask

   task automatic store(input logic [0:14] a, input logic [0:127] d, input logic [0:15] m);
      step(1'b1, 1'b1, a, d, m, 1'b1, 1'b0);
   endtask

   task automatic load(input logic [0:14] a, input bit rr);
      step(1'b1, 1'b0, a, '0, '0, rr, 1'b0);
   endtask

   int pool [8];

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wmask = '0;
      bus.rsp_ready = 1'b0;
      flush         = 1'b0;
      reset         = 1'b0;
      #1;
      chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("reset_rsp_rdata", bus.rsp_rdata, '0);
      chk("reset_req_ready", 128'(bus.req_ready), 128'(1));
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Round trip, low address bits ignored.
      store(15'h0010, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
      load(15'h001F, 1'b1);
      chk("roundtrip_valid", 128'(bus.rsp_valid), 128'(1));
      chk("roundtrip_data", bus.rsp_rdata, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      idle(1'b1);

      // Byte masking.
      store(15'h0020, '0, 16'hFFFF);
      store(15'h0020, {16{8'hAA}}, 16'h8001);
      load(15'h0020, 1'b1);
      chk("mask_bytes", bus.rsp_rdata, 128'hAA00_0000_0000_0000_0000_0000_0000_00AA);
      idle(1'b1);

      // Backpressure: A, B accepted, C refused, stores still accepted.
      store(15'h0030, 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0, 16'hFFFF);
      load(15'h0010, 1'b0);
      load(15'h0020, 1'b0);
      load(15'h0030, 1'b0);
      chk("full_ready_low", 128'(bus.req_ready), 128'(0));
      step(1'b1, 1'b1, 15'h0040, 128'h1234, 16'hFFFF, 1'b0, 1'b0);
      idle(1'b1);
      load(15'h0030, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush with two buffered and a load pending.
      load(15'h0010, 1'b0);
      load(15'h0020, 1'b0);
      step(1'b1, 1'b0, 15'h0030, '0, '0, 1'b1, 1'b1);
      idle(1'b1);
      load(15'h0040, 1'b1);
      chk("flush_store_kept", bus.rsp_rdata, 128'h1234);
      idle(1'b1);

      // Asynchronous reset between edges with two buffered.
      load(15'h0010, 1'b0);
      load(15'h0030, 1'b0);
      bus.req_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("areset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("areset_rsp_rdata", bus.rsp_rdata, '0);
      exp_q.delete();
      #1 reset = 1'b1;
      @(negedge clock);
      load(15'h0030, 1'b1);
      idle(1'b1);

      // Top-of-store boundary.
      store(15'h7FF0, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 16'hFFFF);
      load(15'h7FFF, 1'b1);
      load(15'h7FF0, 1'b1);
      idle(1'b1);

      // Randomized traffic over a pre-written pool of quadwords.
      for (int i = 0; i < 8; i++) begin
         pool[i] = (i == 0) ? 2047 : int'($urandom_range(0, 2046));
         store(15'(pool[i] * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      end
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, ($urandom % 3) == 0,
              15'(pool[$urandom_range(0, 7)] * 16 + int'($urandom_range(0, 15))),
              {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
              ($urandom % 2) == 0, ($urandom % 20) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/local_store_responder.md
LOCAL_STORE_RESPONDER -- requirements
Module: local_store_responder

Interface
REQ-001 SHALL have parameter LS_BYTES, default 32768, local store size in bytes (2048 quadwords).
REQ-002 SHALL have parameter RSP_DEPTH, default 2, read-response buffer depth in entries.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush from the SPU.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  [0:14]  byte address; bits [11:14] ignored; quadword index = req_addr[0:10].
REQ-010 SHALL have port req_wdata  input  [0:127]  store data, byte 0 = bits [0:7].
REQ-011 SHALL have port req_wmask  input  [0:15]  store byte enables; bit i enables byte i.
REQ-012 SHALL have port rsp_valid  output  1  load data available.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes the response when high together with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  [0:127]  load data, head of the response buffer.

Function
REQ-015 SHALL hold 2048 x 128-bit storage; contents are not cleared by reset.
REQ-016 SHALL drive req_ready = !flush && (req_write || count < RSP_DEPTH), where count is the number of buffered responses.
REQ-017 SHALL commit an accepted store at that edge, writing only the enabled bytes; stores produce no response.
REQ-018 SHALL, on an accepted load, push storage[index] into the response buffer at that edge, so rsp_valid is high the next cycle: 1-cycle latency when the buffer was empty.
REQ-019 SHALL make a store accepted at edge N visible to a load accepted at edge N+1 or later.
REQ-020 SHALL return responses in strict acceptance order (FIFO, wrap-around pointers, modulo RSP_DEPTH).
REQ-021 SHALL present rsp_rdata from the head entry, holding it stable while rsp_valid && !rsp_ready.
REQ-022 SHALL update count as follows on simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 SHALL NOT admit a load while count == RSP_DEPTH, even if a pop occurs that cycle (no pass-through).
REQ-024 SHALL, on flush high at an edge, set count to 0 and equalise the pointers, discarding all buffered responses including one being popped that cycle (flush wins).
REQ-025 SHALL accept no request in a flush cycle, and SHALL preserve stores committed before the flush.
REQ-026 SHALL drive rsp_rdata = 0 whenever rsp_valid = 0.

Reset
REQ-027 SHALL, while reset is low, immediately force: count = 0; pointers = 0; rsp_valid = 0; rsp_rdata = 0; req_ready = 1 (when flush = 0).
REQ-028 SHALL drop in-flight responses on reset mid-operation, with the first post-reset load answered normally.

Verification
REQ-029 SHALL cover a store/load round trip: store 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, addr 0x0010; then load addr 0x001F -> the next cycle shows rsp_valid = 1 and rsp_rdata equal to the stored value.
REQ-030 SHALL cover byte masking: after an all-zero full store to 0x0020, store all-0xAA data with mask 0x8001 -> a load returns 0xAA000000_00000000_00000000_000000AA.
REQ-031 SHALL cover backpressure: with rsp_ready = 0, three back-to-back loads (A, B, C) -> A and B are accepted and req_ready = 0 for C; after rsp_ready = 1, responses arrive in order A, B, C; stores are still accepted while the buffer is full.
REQ-032 SHALL cover flush: with 2 responses buffered and a load presented, pulse flush -> req_ready = 0 that cycle; the next cycle shows rsp_valid = 0 and count = 0; a prior store is still readable.
REQ-033 SHALL cover asynchronous reset: drop reset between clock edges with 2 responses buffered -> rsp_valid = 0 and rsp_rdata = 0 immediately, without waiting for an edge; storage is intact after release.
REQ-034 SHALL cover the address boundary: load addr 0x7FFF -> returns quadword 2047; load addr 0x7FF0 -> returns the same data.
